// File: rtl/riscy_pkg.sv
// rtl/riscy_pkg.sv - shared ALU operation codes and ALU-sharing controller state type
// Contents: funct3 encodings understood by alu, FSM state enum for alu_share_ctrl.
package riscy_pkg;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SLL  = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b010;
    localparam logic [2:0] ALU_SLTU = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SRL  = 3'b101;
    localparam logic [2:0] ALU_OR   = 3'b110;
    localparam logic [2:0] ALU_AND  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } alu_ctrl_state_t;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational integer ALU shared by several requesters
// Ports: rs1/rs2 operands, funct3 op select, funct7 SUB/SRA modifier, rd result, z zero flag.
module alu #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [2:0]      funct3,
    input  logic            funct7,
    output logic [XLEN-1:0] rd,
    output logic            z
);
    import riscy_pkg::*;

    localparam int SW = $clog2(XLEN);

    logic [SW-1:0]   shamt;
    logic [XLEN-1:0] sra_res;

    assign shamt = rs2[SW-1:0];
    // Kept in its own assignment so the signed shift is not turned logical
    // by an unsigned neighbour inside a conditional expression.
    assign sra_res = $signed(rs1) >>> shamt;

    always_comb begin
        rd = '0;
        case (funct3)
            ALU_ADD:  rd = funct7 ? (rs1 - rs2) : (rs1 + rs2);
            ALU_SLL:  rd = rs1 << shamt;
            ALU_SLT:  rd = {{(XLEN-1){1'b0}}, ($signed(rs1) < $signed(rs2))};
            ALU_SLTU: rd = {{(XLEN-1){1'b0}}, (rs1 < rs2)};
            ALU_XOR:  rd = rs1 ^ rs2;
            ALU_SRL:  rd = funct7 ? sra_res : (rs1 >> shamt);
            ALU_OR:   rd = rs1 | rs2;
            ALU_AND:  rd = rs1 & rs2;
            default:  rd = '0;
        endcase
    end

    assign z = (rd == '0);

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter
// Ports: req request vector, ptr highest-priority index, grant one-hot, grant_idx binary index.
module rr_arbiter #(
    parameter  int N  = 2,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);
    logic found;

    // Search starts at ptr and wraps upward; first requester found wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[(int'(ptr) + k) % N]) begin
                found                        = 1'b1;
                grant[(int'(ptr) + k) % N]   = 1'b1;
                grant_idx                    = IW'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// rtl/alu_share_ctrl.sv - round-robin sequencer sharing one combinational alu among NREQ requesters
// Ports: req_* per-requester valid/ready + operands, alu_* registered ALU drive and
//        combinational result return, rsp_* held response with requester id.
module alu_share_ctrl #(
    parameter  int NREQ = 2,
    parameter  int XLEN = 32,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ-1:0][XLEN-1:0] req_rs1,
    input  logic [NREQ-1:0][XLEN-1:0] req_rs2,
    input  logic [NREQ-1:0][2:0]      req_funct3,
    input  logic [NREQ-1:0]           req_funct7,
    output logic [XLEN-1:0]           alu_rs1,
    output logic [XLEN-1:0]           alu_rs2,
    output logic [2:0]                alu_funct3,
    output logic                      alu_funct7,
    input  logic [XLEN-1:0]           alu_rd,
    input  logic                      alu_z,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [XLEN-1:0]           rsp_rd,
    output logic                      rsp_z,
    output logic [IDW-1:0]            rsp_id
);
    import riscy_pkg::*;

    alu_ctrl_state_t state;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  op_id;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic [IDW-1:0]  ptr_next;
    logic            accept;

    rr_arbiter #(.N(NREQ)) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Ready is a function of req_valid and state only; rsp_ready never reaches it.
    assign req_ready = (state == ST_IDLE) ? grant : '0;
    assign accept    = (state == ST_IDLE) && (|req_valid);
    assign rsp_valid = (state == ST_RESP);
    assign ptr_next  = (grant_idx == IDW'(NREQ - 1)) ? '0 : (grant_idx + IDW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            op_id      <= '0;
            alu_rs1    <= '0;
            alu_rs2    <= '0;
            alu_funct3 <= '0;
            alu_funct7 <= 1'b0;
            rsp_rd     <= '0;
            rsp_z      <= 1'b0;
            rsp_id     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        alu_rs1    <= req_rs1[grant_idx];
                        alu_rs2    <= req_rs2[grant_idx];
                        alu_funct3 <= req_funct3[grant_idx];
                        alu_funct7 <= req_funct7[grant_idx];
                        op_id      <= grant_idx;
                        rr_ptr     <= ptr_next;
                        state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // alu_* were registered last edge, so alu_rd/alu_z have settled.
                    rsp_rd <= alu_rd;
                    rsp_z  <= alu_z;
                    rsp_id <= op_id;
                    state  <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb/tb_alu_share_ctrl.sv - scoreboard bench for alu_share_ctrl with real alu instances
module tb_alu_share_ctrl;
    import riscy_pkg::*;

    localparam int XLEN = 32;

    typedef struct {
        int              id;
        logic [XLEN-1:0] rd;
        logic            z;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: NREQ = 2
    logic [1:0]           a_valid, a_ready;
    logic [1:0][XLEN-1:0] a_rs1, a_rs2;
    logic [1:0][2:0]      a_f3;
    logic [1:0]           a_f7;
    logic [XLEN-1:0]      a_alu_rs1, a_alu_rs2, a_alu_rd;
    logic [2:0]           a_alu_f3;
    logic                 a_alu_f7, a_alu_z;
    logic                 a_rsp_valid, a_rsp_ready, a_rsp_z;
    logic [XLEN-1:0]      a_rsp_rd;
    logic [0:0]           a_rsp_id;

    // Instance B: NREQ = 3
    logic [2:0]           b_valid, b_ready;
    logic [2:0][XLEN-1:0] b_rs1, b_rs2;
    logic [2:0][2:0]      b_f3;
    logic [2:0]           b_f7;
    logic [XLEN-1:0]      b_alu_rs1, b_alu_rs2, b_alu_rd;
    logic [2:0]           b_alu_f3;
    logic                 b_alu_f7, b_alu_z;
    logic                 b_rsp_valid, b_rsp_ready, b_rsp_z;
    logic [XLEN-1:0]      b_rsp_rd;
    logic [1:0]           b_rsp_id;

    alu_share_ctrl #(.NREQ(2), .XLEN(XLEN)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(a_valid), .req_ready(a_ready),
        .req_rs1(a_rs1), .req_rs2(a_rs2), .req_funct3(a_f3), .req_funct7(a_f7),
        .alu_rs1(a_alu_rs1), .alu_rs2(a_alu_rs2), .alu_funct3(a_alu_f3), .alu_funct7(a_alu_f7),
        .alu_rd(a_alu_rd), .alu_z(a_alu_z),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
        .rsp_rd(a_rsp_rd), .rsp_z(a_rsp_z), .rsp_id(a_rsp_id)
    );

    alu #(.XLEN(XLEN)) alu_a (
        .rs1(a_alu_rs1), .rs2(a_alu_rs2), .funct3(a_alu_f3), .funct7(a_alu_f7),
        .rd(a_alu_rd), .z(a_alu_z)
    );

    alu_share_ctrl #(.NREQ(3), .XLEN(XLEN)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_valid), .req_ready(b_ready),
        .req_rs1(b_rs1), .req_rs2(b_rs2), .req_funct3(b_f3), .req_funct7(b_f7),
        .alu_rs1(b_alu_rs1), .alu_rs2(b_alu_rs2), .alu_funct3(b_alu_f3), .alu_funct7(b_alu_f7),
        .alu_rd(b_alu_rd), .alu_z(b_alu_z),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_rd(b_rsp_rd), .rsp_z(b_rsp_z), .rsp_id(b_rsp_id)
    );

    alu #(.XLEN(XLEN)) alu_b (
        .rs1(b_alu_rs1), .rs2(b_alu_rs2), .funct3(b_alu_f3), .funct7(b_alu_f7),
        .rd(b_alu_rd), .z(b_alu_z)
    );

    exp_t qa[$];
    exp_t qb[$];

    function automatic exp_t mk(input int id, input logic [XLEN-1:0] rd);
        exp_t e;
        e.id = id;
        e.rd = rd;
        e.z  = (rd == '0);
        return e;
    endfunction

    // Response scoreboards: pop one entry per completed response handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && a_rsp_valid && a_rsp_ready) begin
            vectors++;
            if (qa.size() == 0) begin
                miscompares++;
                $display("FAIL rsp_a_unexpected: got id=%0d rd=%0d, none expected", a_rsp_id, a_rsp_rd);
            end else begin
                e = qa.pop_front();
                if (a_rsp_rd !== e.rd || a_rsp_z !== e.z || int'(a_rsp_id) !== e.id) begin
                    miscompares++;
                    $display("FAIL rsp_a: got id=%0d rd=%0d z=%0b, expected id=%0d rd=%0d z=%0b",
                             a_rsp_id, a_rsp_rd, a_rsp_z, e.id, e.rd, e.z);
                end
            end
        end
        if (rst_n && b_rsp_valid && b_rsp_ready) begin
            vectors++;
            if (qb.size() == 0) begin
                miscompares++;
                $display("FAIL rsp_b_unexpected: got id=%0d rd=%0d, none expected", b_rsp_id, b_rsp_rd);
            end else begin
                e = qb.pop_front();
                if (b_rsp_rd !== e.rd || b_rsp_z !== e.z || int'(b_rsp_id) !== e.id) begin
                    miscompares++;
                    $display("FAIL rsp_b: got id=%0d rd=%0d z=%0b, expected id=%0d rd=%0d z=%0b",
                             b_rsp_id, b_rsp_rd, b_rsp_z, e.id, e.rd, e.z);
                end
            end
        end
    end

    // Waits for a request handshake on instance A; returns just after that edge.
    task automatic wait_hs(output logic [1:0] rdy, output bit ok);
        ok  = 1'b0;
        rdy = '0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if ((a_valid & a_ready) != 2'b00) begin
                rdy = a_ready;
                ok  = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_valid = '0; a_rs1 = '0; a_rs2 = '0; a_f3 = '0; a_f7 = '0; a_rsp_ready = 1'b1;
        b_valid = '0; b_rs1 = '0; b_rs2 = '0; b_f3 = '0; b_f7 = '0; b_rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (a_ready !== 2'b00 || a_rsp_valid !== 1'b0 || a_rsp_rd !== '0 || a_rsp_z !== 1'b0
            || a_rsp_id !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_rsp: ready=%b valid=%b rd=%0d z=%b id=%0d, expected all 0",
                     a_ready, a_rsp_valid, a_rsp_rd, a_rsp_z, a_rsp_id);
        end
        vectors++;
        if (a_alu_rs1 !== '0 || a_alu_rs2 !== '0 || a_alu_f3 !== 3'b000 || a_alu_f7 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_alu: rs1=%0d rs2=%0d f3=%0d f7=%b, expected all 0",
                     a_alu_rs1, a_alu_rs2, a_alu_f3, a_alu_f7);
        end
        vectors++;
        if (b_ready !== 3'b000 || b_rsp_valid !== 1'b0 || b_rsp_id !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_b: ready=%b valid=%b id=%0d, expected 0 0 0", b_ready, b_rsp_valid, b_rsp_id);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        logic [1:0] rdy;
        bit ok;
        a_rs1[0] = 32'd20; a_rs2[0] = 32'd30; a_f3[0] = ALU_ADD; a_f7[0] = 1'b0;
        a_valid = 2'b01;
        qa.push_back(mk(0, 32'd50));
        wait_hs(rdy, ok);
        a_valid = 2'b00;
        vectors++;
        if (!ok || rdy !== 2'b01) begin
            miscompares++;
            $display("FAIL single_grant: ready=%b ok=%0d, expected 01", rdy, ok);
        end
        vectors++;
        if (a_alu_rs1 !== 32'd20 || a_alu_rs2 !== 32'd30 || a_alu_f3 !== ALU_ADD) begin
            miscompares++;
            $display("FAIL single_alu_regs: rs1=%0d rs2=%0d f3=%0d, expected 20 30 0", a_alu_rs1, a_alu_rs2, a_alu_f3);
        end
        @(negedge clk);
        vectors++;
        if (a_rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_exec_valid: rsp_valid=%b, expected 0 one cycle after handshake", a_rsp_valid);
        end
        @(negedge clk);
        vectors++;
        if (a_rsp_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL single_latency: rsp_valid=%b, expected 1 two cycles after handshake", a_rsp_valid);
        end
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (a_alu_rs1 !== 32'd20 || a_rsp_valid !== 1'b0 || qa.size() != 0) begin
            miscompares++;
            $display("FAIL single_after: alu_rs1=%0d rsp_valid=%b pending=%0d, expected 20 0 0",
                     a_alu_rs1, a_rsp_valid, qa.size());
        end
    endtask

    task automatic test_reset_mid_exec();
        logic [1:0] rdy;
        bit ok;
        a_rs1[0] = 32'd20; a_rs2[0] = 32'd30; a_f3[0] = ALU_ADD; a_f7[0] = 1'b0;
        a_rs1[1] = 32'd5;  a_rs2[1] = 32'd6;  a_f3[1] = ALU_XOR; a_f7[1] = 1'b0;
        a_valid = 2'b01;
        wait_hs(rdy, ok);
        a_valid = 2'b00;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (a_rsp_valid !== 1'b0 || a_rsp_rd !== '0 || a_alu_rs1 !== '0) begin
            miscompares++;
            $display("FAIL midexec_async: valid=%b rd=%0d alu_rs1=%0d, expected 0 0 0",
                     a_rsp_valid, a_rsp_rd, a_alu_rs1);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if (a_rsp_valid !== 1'b0 || a_rsp_rd !== '0 || a_rsp_z !== 1'b0 || a_rsp_id !== 1'b0) begin
                miscompares++;
                $display("FAIL midexec_noresp: valid=%b rd=%0d z=%b id=%0d, expected all 0",
                         a_rsp_valid, a_rsp_rd, a_rsp_z, a_rsp_id);
            end
        end
        @(posedge clk);
        #1;
        a_valid = 2'b11;
        qa.push_back(mk(0, 32'd50));
        wait_hs(rdy, ok);
        a_valid = 2'b00;
        vectors++;
        if (!ok || rdy !== 2'b01) begin
            miscompares++;
            $display("FAIL midexec_ptr_reset: ready=%b ok=%0d, expected 01", rdy, ok);
        end
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (qa.size() != 0) begin
            miscompares++;
            $display("FAIL midexec_drain: pending=%0d, expected 0", qa.size());
        end
    endtask

    task automatic test_sub();
        logic [1:0] rdy;
        bit ok;
        a_rs1[1] = 32'd20; a_rs2[1] = 32'd20; a_f3[1] = ALU_ADD; a_f7[1] = 1'b1;
        a_valid = 2'b10;
        qa.push_back(mk(1, 32'd0));
        wait_hs(rdy, ok);
        a_valid = 2'b00;
        vectors++;
        if (!ok || rdy !== 2'b10) begin
            miscompares++;
            $display("FAIL sub_grant: ready=%b ok=%0d, expected 10", rdy, ok);
        end
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (qa.size() != 0) begin
            miscompares++;
            $display("FAIL sub_drain: pending=%0d, expected 0", qa.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] rdy;
        bit ok;
        int last;
        a_rs1[0] = 32'd8;  a_rs2[0] = 32'd3;  a_f3[0] = ALU_SLL; a_f7[0] = 1'b0;
        a_rs1[1] = 32'd20; a_rs2[1] = 32'd30; a_f3[1] = ALU_AND; a_f7[1] = 1'b0;
        a_rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) qa.push_back(mk(k % 2, (k % 2 == 1) ? 32'd20 : 32'd64));
        a_valid = 2'b11;
        last = 0;
        for (int k = 0; k < 4; k++) begin
            wait_hs(rdy, ok);
            vectors++;
            if (!ok || rdy !== ((k % 2 == 1) ? 2'b10 : 2'b01)) begin
                miscompares++;
                $display("FAIL b2b_grant%0d: ready=%b ok=%0d, expected %b", k, rdy, ok,
                         (k % 2 == 1) ? 2'b10 : 2'b01);
            end
            if (k > 0) begin
                vectors++;
                if (cyc - last != 3) begin
                    miscompares++;
                    $display("FAIL b2b_gap%0d: %0d cycles between grants, expected 3", k, cyc - last);
                end
            end
            last = cyc;
        end
        a_valid = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (qa.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_drain: pending=%0d, expected 0", qa.size());
        end
    endtask

    task automatic test_stall();
        logic [1:0] rdy;
        bit ok;
        a_rs1[0] = 32'd8;  a_rs2[0] = 32'd3;  a_f3[0] = ALU_SRL; a_f7[0] = 1'b0;
        a_rs1[1] = 32'd20; a_rs2[1] = 32'd30; a_f3[1] = ALU_XOR; a_f7[1] = 1'b0;
        a_rsp_ready = 1'b0;
        qa.push_back(mk(0, 32'd1));
        qa.push_back(mk(1, 32'd10));
        a_valid = 2'b11;
        wait_hs(rdy, ok);
        a_valid = 2'b10;
        vectors++;
        if (!ok || rdy !== 2'b01) begin
            miscompares++;
            $display("FAIL stall_first_grant: ready=%b ok=%0d, expected 01", rdy, ok);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if (a_rsp_valid !== 1'b1 || a_rsp_rd !== 32'd1 || a_rsp_id !== 1'b0 || a_ready !== 2'b00) begin
                miscompares++;
                $display("FAIL stall_hold%0d: valid=%b rd=%0d id=%0d ready=%b, expected 1 1 0 00",
                         i, a_rsp_valid, a_rsp_rd, a_rsp_id, a_ready);
            end
            @(posedge clk);
            #1;
        end
        a_rsp_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (a_ready !== 2'b00) begin
            miscompares++;
            $display("FAIL stall_release_ready: ready=%b, expected 00 while in RESP", a_ready);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        vectors++;
        if (a_ready !== 2'b10) begin
            miscompares++;
            $display("FAIL stall_req1_grant: ready=%b, expected 10", a_ready);
        end
        @(posedge clk);
        #1;
        a_valid = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (qa.size() != 0) begin
            miscompares++;
            $display("FAIL stall_drain: pending=%0d, expected 0", qa.size());
        end
    endtask

    task automatic test_nreq3();
        b_rs1[2] = 32'd20; b_rs2[2] = 32'd30; b_f3[2] = ALU_OR;  b_f7[2] = 1'b0;
        b_rs1[0] = 32'd7;  b_rs2[0] = 32'd7;  b_f3[0] = ALU_XOR; b_f7[0] = 1'b0;
        b_rs1[1] = 32'd1;  b_rs2[1] = 32'd1;  b_f3[1] = ALU_ADD; b_f7[1] = 1'b0;
        b_rsp_ready = 1'b1;
        b_valid = 3'b100;
        qb.push_back(mk(2, 32'd30));
        @(negedge clk);
        vectors++;
        if (b_ready !== 3'b100) begin
            miscompares++;
            $display("FAIL n3_grant2: ready=%b, expected 100", b_ready);
        end
        @(posedge clk);
        #1;
        b_valid = 3'b000;
        repeat (4) @(posedge clk);
        #1;
        b_valid = 3'b111;
        qb.push_back(mk(0, 32'd0));
        @(negedge clk);
        vectors++;
        if (b_ready !== 3'b001) begin
            miscompares++;
            $display("FAIL n3_wrap: ready=%b, expected 001", b_ready);
        end
        @(posedge clk);
        #1;
        b_valid = 3'b000;
        repeat (4) @(posedge clk);
        #1;
        vectors++;
        if (qb.size() != 0) begin
            miscompares++;
            $display("FAIL n3_drain: pending=%0d, expected 0", qb.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_reset_mid_exec();
        test_sub();
        test_back_to_back();
        test_stall();
        test_nreq3();
        vectors++;
        if (qa.size() != 0 || qb.size() != 0) begin
            miscompares++;
            $display("FAIL final_queues: pending a=%0d b=%0d, expected 0 0", qa.size(), qb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Sequencer and round-robin arbiter that shares the single combinational `alu` between NREQ requesters (e.g. execute stage, branch-compare unit, address generator). It accepts one operation at a time over a valid/ready handshake, registers operands onto the ALU's `rs1`/`rs2`/`funct3`/`funct7` inputs, and captures `rd`/`z` into a held response tagged with the requester index. It sits between the decode/issue logic and the `alu` instance in the core.

## Interface
- NREQ, 2, number of requesters (2..4)
- XLEN, 32, operand/result width
- IDW, $clog2(NREQ), requester-ID width (derived, not overridden)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; at most one bit high
- req_rs1, req_rs2  in  NREQ×XLEN  operands (packed, requester i at [i])
- req_funct3  in  NREQ×3  ALU operation select
- req_funct7  in  NREQ  SUB/SRA modifier bit
- alu_rs1, alu_rs2  out  XLEN  to ALU
- alu_funct3  out  3  to ALU
- alu_funct7  out  1  to ALU
- alu_rd  in  XLEN  ALU result (combinational from alu_* outputs)
- alu_z  in  1  ALU zero flag
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_rd  out  XLEN  captured result
- rsp_z  out  1  captured zero flag
- rsp_id  out  IDW  index of requester that issued the op

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state IDLE.
- IDLE: req_ready = one-hot grant from round-robin arbiter over req_valid; all zero if no request. On edge with any req_valid: latch granted requester's operands/funct into alu_* regs, latch id, rr pointer := grant+1 mod NREQ, go EXEC.
- EXEC: req_ready = 0. ALU settles combinationally; on edge capture alu_rd→rsp_rd, alu_z→rsp_z, go RESP.
- RESP: rsp_valid = 1, rsp_rd/rsp_z/rsp_id stable. On edge with rsp_ready: go IDLE. Otherwise hold indefinitely.
- Round-robin: priority starts at rr pointer, searches upward with wrap; rr pointer resets to 0. Requester not granted keeps valid high; its operands must stay stable until its ready (standard valid/ready).
- req_ready depends on req_valid only (no combinational path from rsp_ready to req_ready).
- alu_* registers hold last issued op between operations (no forced zero after reset-time value).
- Requester dropping req_valid without grant: legal, no effect.

## Timing
- Reset values: req_ready 0 until first IDLE cycle after reset release (comb, so 0 only if no valid), rsp_valid 0, rsp_rd 0, rsp_z 0, rsp_id 0, alu_rs1/alu_rs2 0, alu_funct3 0, alu_funct7 0, rr pointer 0.
- Latency: handshake at edge T → alu_* valid after T → rsp_valid high after edge T+1 → earliest next grant at edge T+3 (rsp_ready high throughout). Max throughput one op per 3 cycles.
- rsp_ready low in RESP: stall, outputs unchanged, no new grant.
- rst_n asserted in any state: immediately IDLE, all outputs to reset values; in-flight op discarded, no response.
- Simultaneous valid from all requesters: grants in strict rotation, each gets one op per NREQ ops.

## Structure
- Shared package `riscy_pkg`: funct3 constants (ALU_ADD=000, ALU_SLL=001, ALU_SLT=010, ALU_SLTU=011, ALU_XOR=100, ALU_SRL=101, ALU_OR=110, ALU_AND=111), state enum alu_ctrl_state_t.
- One sub-module `rr_arbiter` (parameter N; ports req, ptr, grant one-hot, grant_idx) — combinational, reused by future regfile/memory port sharing.
- Bench instantiates real `alu` between alu_* ports.

## Test plan
- Reset mid-EXEC (req0 ADD 20+30 granted, rst_n low next cycle) → rsp_valid 0, rsp_* 0, next grant starts from requester 0.
- Single req0 ADD rs1=20, rs2=30, rsp_ready=1 → rsp_valid two cycles after handshake, rsp_rd=50, rsp_z=0, rsp_id=0.
- req1 SUB (funct7=1) 20−20 → rsp_rd=0, rsp_z=1, rsp_id=1.
- req0 and req1 both valid continuously (SLL 8,3 and AND 20,30) → responses alternate id 0,1,0,1 with rd 64, 20, 64, 20.
- rsp_ready held low 5 cycles in RESP with req0 SRL 8,3 pending plus req1 waiting → rsp_rd=1 stable, req_ready all 0 during stall, req1 granted the cycle after rsp_ready rises and FSM returns to IDLE.
- NREQ=3, only req2 valid (OR 20,30) → req_ready=3'b100, rsp_rd=30, rsp_id=2; rr pointer wraps to 0.
